// File: rtl/display.sv
// display: debug readout for the data-driven processor board.
// Shows one byte, either the program counter or a field of the current token
// packet, as two hex digits on a multiplexed two-digit seven-segment display.
// Each rising edge of the DISP_SWITCH push-button advances the display mode.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   DISP_SWITCH  asynchronous push-button, active-high; a rise advances the mode
//   PC[4:0]      current program counter, sampled live
//   PACKET_IN    token packet {TYPE[2:0], DEST[7:0], GEN[6:0], FLAGS[3:0], DATA[15:0]}
//   TOGLE        digit select: 0 = low-nibble digit, 1 = high-nibble digit
//   nHEX[7:0]    active-low segments {dp,g,f,e,d,c,b,a}, registered
module display #(
    parameter int SCAN_DIV = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DISP_SWITCH,
    input  logic [4:0]  PC,
    input  logic [37:0] PACKET_IN,
    output logic        TOGLE,
    output logic [7:0]  nHEX
);

    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic          s1, s2, s_prev, rise;
    logic [2:0]    mode, mode_nxt;
    logic [CW-1:0] cnt;
    logic          wrap, togle_nxt;
    logic [7:0]    byte_sel;
    logic [3:0]    nib;
    logic [7:0]    seg;

    // Button synchronizer and rise detector. A held button produces one rise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s1     <= DISP_SWITCH;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign rise = s2 & ~s_prev;

    // Mode state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) mode <= 3'd0;
        else      mode <= mode_nxt;
    end

    // Next mode: step 0..5 and wrap; the unused encodings also fall back to 0.
    always_comb begin
        mode_nxt = mode;
        if (rise) mode_nxt = (mode >= 3'd5) ? 3'd0 : mode + 3'd1;
    end

    // Byte selection follows the mode being entered, so the digit registered
    // on the advancing edge already shows the new field.
    always_comb begin
        byte_sel = {3'b000, PC};
        case (mode_nxt)
            3'd1:    byte_sel = PACKET_IN[7:0];
            3'd2:    byte_sel = PACKET_IN[15:8];
            3'd3:    byte_sel = PACKET_IN[34:27];
            3'd4:    byte_sel = {1'b0, PACKET_IN[26:20]};
            3'd5:    byte_sel = {1'b0, PACKET_IN[37:35], PACKET_IN[19:16]};
            default: byte_sel = {3'b000, PC};
        endcase
    end

    // Scan divider: TOGLE flips on the edge where the counter wraps.
    assign wrap      = (cnt == CNT_MAX);
    assign togle_nxt = TOGLE ^ wrap;

    // Nibble chosen with the TOGLE value being registered alongside nHEX,
    // so the segments always match the digit currently selected.
    assign nib = togle_nxt ? byte_sel[7:4] : byte_sel[3:0];

    always_comb begin
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt   <= '0;
            TOGLE <= 1'b0;
            nHEX  <= 8'hFF;
        end else begin
            cnt   <= wrap ? '0 : cnt + CW'(1);
            TOGLE <= togle_nxt;
            nHEX  <= seg;
        end
    end

endmodule

// File: tb/tb_display.sv
// Bench for display: two instances (SCAN_DIV=1 and SCAN_DIV=4) share inputs.
// The reference model counts clock edges since reset and button rises, and
// derives the expected digit from the mode table and the hex segment table.
module tb_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sw  = 1'b0;
    logic [4:0]  pc  = 5'd0;
    logic [37:0] pkt = 38'd0;
    logic        tog1, tog4;
    logic [7:0]  nhex1, nhex4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display #(.SCAN_DIV(1)) dut1 (
        .CLK(clk), .RST(rst), .DISP_SWITCH(sw), .PC(pc), .PACKET_IN(pkt),
        .TOGLE(tog1), .nHEX(nhex1)
    );

    display #(.SCAN_DIV(4)) dut4 (
        .CLK(clk), .RST(rst), .DISP_SWITCH(sw), .PC(pc), .PACKET_IN(pkt),
        .TOGLE(tog4), .nHEX(nhex4)
    );

    // Model: edges since reset release, mode, and edges since a sampled rise.
    int m_n    = 0;
    int m_mode = 0;
    int m_pend = 0;
    bit m_prev = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n    <= 0;
            m_mode <= 0;
            m_pend <= 0;
            m_prev <= 1'b0;
        end else begin
            m_n    <= m_n + 1;
            m_prev <= sw;
            if (m_pend == 2) begin
                m_mode <= (m_mode + 1) % 6;
                m_pend <= 0;
            end else if (m_pend > 0) begin
                m_pend <= m_pend + 1;
            end else if (sw && !m_prev) begin
                m_pend <= 1;
            end
        end
    end

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(input int md, input int n, input bit t);
        logic [7:0] b;
        if (n == 0) return 8'hFF;
        case (md)
            1:       b = pkt[7:0];
            2:       b = pkt[15:8];
            3:       b = pkt[34:27];
            4:       b = {1'b0, pkt[26:20]};
            5:       b = {1'b0, pkt[37:35], pkt[19:16]};
            default: b = {3'b000, pc};
        endcase
        return seg_of(t ? b[7:4] : b[3:0]);
    endfunction

    function automatic bit exp_tog(input int n, input int div);
        return 1'((n / div) % 2);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        pc  = 5'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk += 2;
            if (nhex1 !== 8'hFF || nhex4 !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_nhex got %h/%h exp FF", nhex1, nhex4);
            end
            if (tog1 !== 1'b0 || tog4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_togle got %b/%b exp 0", tog1, tog4);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk += 2;
            if (tog1 !== exp_tog(m_n, 1)) begin
                n_fail++;
                $display("FAIL release_togle got %b exp %b", tog1, exp_tog(m_n, 1));
            end
            if (nhex1 !== (tog1 ? 8'hC0 : 8'hB0)) begin
                n_fail++;
                $display("FAIL release_nhex got %h exp %h", nhex1, tog1 ? 8'hC0 : 8'hB0);
            end
        end
    endtask

    task automatic test_mode_step();
        logic [7:0] lo_t [6];
        logic [7:0] hi_t [6];
        lo_t = '{8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0};
        hi_t = '{8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hF8, 8'hC0};
        pkt = {3'b111, 8'h00, 7'd0, 4'b0, 16'd120};
        for (int p = 0; p < 6; p++) begin
            sw = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                n_chk += 2;
                if (tog1 !== exp_tog(m_n, 1)) begin
                    n_fail++;
                    $display("FAIL step%0d_togle got %b exp %b", p, tog1, exp_tog(m_n, 1));
                end
                if (nhex1 !== exp_hex(m_mode, m_n, exp_tog(m_n, 1))) begin
                    n_fail++;
                    $display("FAIL step%0d_nhex got %h exp %h", p, nhex1,
                             exp_hex(m_mode, m_n, exp_tog(m_n, 1)));
                end
                sw = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                n_chk++;
                if (nhex1 !== (tog1 ? hi_t[p] : lo_t[p])) begin
                    n_fail++;
                    $display("FAIL step%0d_const got %h exp %h", p, nhex1, tog1 ? hi_t[p] : lo_t[p]);
                end
            end
        end
    endtask

    task automatic test_held();
        sw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_chk++;
            if (nhex1 !== exp_hex(m_mode, m_n, exp_tog(m_n, 1))) begin
                n_fail++;
                $display("FAIL held_nhex got %h exp %h", nhex1, exp_hex(m_mode, m_n, exp_tog(m_n, 1)));
            end
            if (i == 9) sw = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (nhex1 !== (tog1 ? 8'hF8 : 8'h80)) begin
                n_fail++;
                $display("FAIL held_one_advance got %h exp %h", nhex1, tog1 ? 8'hF8 : 8'h80);
            end
        end
    endtask

    task automatic test_scan_div();
        int hi_run;
        rst = 1'b0;
        @(negedge clk);
        pc  = 5'h1A;
        rst = 1'b1;
        hi_run = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_chk += 2;
            if (tog4 !== exp_tog(m_n, 4)) begin
                n_fail++;
                $display("FAIL div4_togle cyc%0d got %b exp %b", i, tog4, exp_tog(m_n, 4));
            end
            if (nhex4 !== exp_hex(m_mode, m_n, exp_tog(m_n, 4))) begin
                n_fail++;
                $display("FAIL div4_nhex cyc%0d got %h exp %h", i, nhex4,
                         exp_hex(m_mode, m_n, exp_tog(m_n, 4)));
            end
            if (i >= 3 && i < 7 && tog4 === 1'b1) hi_run++;
        end
        n_chk++;
        if (hi_run !== 4) begin
            n_fail++;
            $display("FAIL div4_high_run got %0d exp 4", hi_run);
        end
    endtask

    task automatic test_random();
        int w;
        w = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_chk += 4;
            if (tog1 !== exp_tog(m_n, 1)) begin
                n_fail++;
                $display("FAIL rnd_tog1 cyc%0d got %b exp %b", i, tog1, exp_tog(m_n, 1));
            end
            if (nhex1 !== exp_hex(m_mode, m_n, exp_tog(m_n, 1))) begin
                n_fail++;
                $display("FAIL rnd_nhex1 cyc%0d got %h exp %h", i, nhex1, exp_hex(m_mode, m_n, exp_tog(m_n, 1)));
            end
            if (tog4 !== exp_tog(m_n, 4)) begin
                n_fail++;
                $display("FAIL rnd_tog4 cyc%0d got %b exp %b", i, tog4, exp_tog(m_n, 4));
            end
            if (nhex4 !== exp_hex(m_mode, m_n, exp_tog(m_n, 4))) begin
                n_fail++;
                $display("FAIL rnd_nhex4 cyc%0d got %h exp %h", i, nhex4, exp_hex(m_mode, m_n, exp_tog(m_n, 4)));
            end
            pc  = 5'($urandom());
            pkt = {6'($urandom()), $urandom()};
            if (i % 8 == 0) w = int'($urandom_range(1, 4));
            sw = ((i % 8) < w);
        end
        sw = 1'b0;
    endtask

    task automatic test_reset_mid();
        int tries;
        tries = 0;
        pkt = {3'b010, 8'h5C, 7'h33, 4'hA, 16'h9E1F};
        pc  = 5'h17;
        while (m_mode != 3 && tries < 8) begin
            sw = 1'b1;
            repeat (2) @(negedge clk);
            sw = 1'b0;
            repeat (4) @(negedge clk);
            tries++;
        end
        n_chk++;
        if (nhex1 !== (tog1 ? 8'h92 : 8'hC6)) begin
            n_fail++;
            $display("FAIL mid_mode3_dest got %h exp %h", nhex1, tog1 ? 8'h92 : 8'hC6);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk += 2;
        if (nhex1 !== 8'hFF || nhex4 !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_async_nhex got %h/%h exp FF", nhex1, nhex4);
        end
        if (tog1 !== 1'b0 || tog4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_togle got %b/%b exp 0", tog1, tog4);
        end
        sw = 1'b1;
        repeat (3) @(negedge clk);
        sw  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (nhex1 !== (tog1 ? 8'hF9 : 8'hF8)) begin
                n_fail++;
                $display("FAIL mid_resume_pc got %h exp %h", nhex1, tog1 ? 8'hF9 : 8'hF8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_step();
        test_held();
        test_scan_div();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
